// File: rtl/dlx_issue_seq.sv
// dlx_issue_seq: instruction issue sequencer for the DLX execute stage.
// Decoded instructions are queued in a DEPTH-entry FIFO and handed to the
// execute stage one at a time. ALU/shift ops issue back-to-back. Memory ops
// hold the execute inputs stable until mem_ack completes the handshake.
// Optional feature: define DLX_SEQ_TIMEOUT_EN to add a MEM_WAIT timeout that
// parks the sequencer in ERR with a sticky err flag, released by clr_err.
module dlx_issue_seq #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_opselect,
    input  logic [2:0]        in_operation,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [15:0]       in_imm,
    output logic              enable_ex,
    output logic [6:0]        control_in,
    output logic [DATA_W-1:0] src1,
    output logic [DATA_W-1:0] src2,
    output logic [DATA_W-1:0] imm,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              retire,
    output logic              illegal_op,
    output logic              err,
    input  logic              clr_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 7 + 2 * DATA_W + 16;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_MEM_WAIT,
        S_ERR
    } state_t;

    // FIFO storage and bookkeeping
    logic [ENT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;

    // Sequencer state and registered execute-stage outputs
    state_t            r_state;
    logic              r_enableEx;
    logic              r_memReq;
    logic              r_illegalOp;
    logic [6:0]        r_control;
    logic [DATA_W-1:0] r_src1;
    logic [DATA_W-1:0] r_src2;
    logic [DATA_W-1:0] r_imm;

`ifdef DLX_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);
    logic              r_err;
    logic [TO_W-1:0]   r_toCnt;
`else
    logic              w_unusedClr;
`endif

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_advance;
    logic              w_pop;
    logic [ENT_W-1:0]  w_head;
    logic [6:0]        w_headCtrl;
    logic [2:0]        w_headOpsel;
    logic [DATA_W-1:0] w_headSrc1;
    logic [DATA_W-1:0] w_headSrc2;
    logic [15:0]       w_headImm;
    logic              w_headLegal;
    logic              w_headMem;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && !w_full;
    assign in_ready = !w_full;

    // The sequencer may take a new instruction when it is idle, has just
    // issued an ALU/shift op, or sees the ack that finishes a memory op.
    assign w_advance = (r_state == S_IDLE) || (r_state == S_ISSUE) ||
                       ((r_state == S_MEM_WAIT) && mem_ack);
    assign w_pop     = w_advance && !w_empty;

    assign w_head      = r_mem[r_rdPtr];
    assign w_headCtrl  = w_head[ENT_W-1 -: 7];
    assign w_headOpsel = w_headCtrl[5:3];
    assign w_headSrc1  = w_head[16+2*DATA_W-1 -: DATA_W];
    assign w_headSrc2  = w_head[16+DATA_W-1 -: DATA_W];
    assign w_headImm   = w_head[15:0];
    assign w_headLegal = (w_headOpsel == 3'b000) || (w_headOpsel == 3'b001) ||
                         (w_headOpsel == 3'b100) || (w_headOpsel == 3'b101);
    assign w_headMem   = w_headOpsel[2];

    // Write accepted instructions into the FIFO array (no reset needed on data)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {in_use_imm, in_opselect, in_operation,
                               in_src1, in_src2, in_imm};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue FSM: decodes the popped head and registers the execute-stage outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_enableEx  <= 1'b0;
            r_memReq    <= 1'b0;
            r_illegalOp <= 1'b0;
            r_control   <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_imm       <= '0;
`ifdef DLX_SEQ_TIMEOUT_EN
            r_err       <= 1'b0;
            r_toCnt     <= '0;
`endif
        end else begin
            r_illegalOp <= 1'b0;
            if (w_advance) begin
                r_state    <= S_IDLE;
                r_enableEx <= 1'b0;
                r_memReq   <= 1'b0;
`ifdef DLX_SEQ_TIMEOUT_EN
                r_toCnt    <= '0;
`endif
                if (w_pop) begin
                    if (w_headLegal) begin
                        r_state    <= w_headMem ? S_MEM_WAIT : S_ISSUE;
                        r_enableEx <= 1'b1;
                        r_memReq   <= w_headMem;
                        r_control  <= w_headCtrl;
                        r_src1     <= w_headSrc1;
                        r_src2     <= w_headSrc2;
                        r_imm      <= {{(DATA_W-16){w_headImm[15]}}, w_headImm};
                    end else begin
                        r_illegalOp <= 1'b1;
                    end
                end
            end
`ifdef DLX_SEQ_TIMEOUT_EN
            else if (r_state == S_MEM_WAIT) begin
                if (r_toCnt == TO_LAST) begin
                    r_state    <= S_ERR;
                    r_err      <= 1'b1;
                    r_enableEx <= 1'b0;
                    r_memReq   <= 1'b0;
                end else begin
                    r_toCnt <= r_toCnt + TO_W'(1);
                end
            end else if ((r_state == S_ERR) && clr_err) begin
                r_err   <= 1'b0;
                r_state <= S_IDLE;
            end
`endif
        end
    end

    assign enable_ex  = r_enableEx;
    assign mem_req    = r_memReq;
    assign illegal_op = r_illegalOp;
    assign control_in = r_control;
    assign src1       = r_src1;
    assign src2       = r_src2;
    assign imm        = r_imm;

    // Retire lands in the completing cycle itself so a memory op finishing and
    // the next ALU op issuing on the following cycle give two distinct pulses.
    assign retire = (r_state == S_ISSUE) || ((r_state == S_MEM_WAIT) && mem_ack);

`ifdef DLX_SEQ_TIMEOUT_EN
    assign err = r_err;
`else
    assign err         = 1'b0;
    assign w_unusedClr = clr_err ^ (MEM_TIMEOUT < 0);
`endif

endmodule

// File: doc/dlx_issue_seq.md
# dlx_issue_seq

Instruction issue sequencer for the DLX execute stage. Buffers decoded instructions in a small FIFO and drives the execute-stage inputs one instruction at a time: `enable_ex`, `control_in`, `src1`, `src2`, `imm`. ALU and shift operations issue back-to-back. For memory operations it holds the execute inputs stable and handshakes with data memory (`mem_req`/`mem_ack`) before it issues the next instruction.

## Interface
Parameters:
- `DATA_W`, 32: operand width.
- `DEPTH`, 4: FIFO entries; must be a power of 2, at least 2.
- `MEM_TIMEOUT`, 15: maximum `MEM_WAIT` cycles before error (used only with the macro).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream instruction valid.
- `in_ready` out 1: FIFO can accept; equals `!full`.
- `in_opselect` in 3: 000 shift, 001 arith/logic, 100 mem write, 101 mem read.
- `in_operation` in 3: ALU, shift or load-type code.
- `in_use_imm` in 1: use the immediate as the second operand.
- `in_src1`, `in_src2` in `DATA_W`: register operands.
- `in_imm` in 16: raw immediate.
- `enable_ex` out 1: execute stage enable.
- `control_in` out 7: `{use_imm, opselect[2:0], operation[2:0]}`.
- `src1`, `src2` out `DATA_W`: registered operands.
- `imm` out `DATA_W`: `in_imm` sign-extended to `DATA_W`.
- `mem_req` out 1: memory access request.
- `mem_ack` in 1: memory access complete.
- `retire` out 1: one-cycle pulse per completed instruction.
- `illegal_op` out 1: one-cycle pulse when an illegal opselect is dropped.
- `err` out 1: sticky memory timeout flag (macro only; otherwise tied to 0).
- `clr_err` in 1: clears `err` (macro only; otherwise ignored).

## Operation
- **FIFO:**
  - A push happens when `in_valid && in_ready`.
  - There is no bypass: a push into a full FIFO cannot occur.
  - Pointers wrap modulo `DEPTH`. An occupancy counter of width log2(`DEPTH`)+1 is kept.
  - A push and a pop in the same cycle leave the count unchanged.
- **FSM states:** `IDLE`, `ISSUE`, `MEM_WAIT`, `ERR`.
  - **`IDLE`:** while the FIFO is non-empty, pop the head. Then:
    - Legal opselect: register the outputs and go to `ISSUE`, or to `MEM_WAIT` for opselect 10x.
    - Illegal opselect (01x, 11x): pulse `illegal_op`, assert no `enable_ex`, stay in `IDLE`.
  - **`ISSUE`:** `enable_ex`=1 for exactly one cycle and `retire`=1 in the same cycle. Then:
    - If the FIFO is non-empty, pop the next entry and decode it the same way as in `IDLE` (continuous issue).
    - Otherwise go to `IDLE`.
  - **`MEM_WAIT`:** `enable_ex`=1 and `mem_req`=1. `src1`, `src2`, `imm` and `control_in` are held constant.
    - On `mem_ack`=1: `retire`=1 that cycle, then behave as `ISSUE` for the next pop.
    - `mem_req` deasserts in the cycle after the ack.
  - **`ERR`:** see Configuration.
- **Outputs outside active states:** when not in `ISSUE` or `MEM_WAIT`, `enable_ex`=0 and `mem_req`=0. The data outputs hold their last values.
- **`mem_ack` outside `MEM_WAIT`:** ignored.
- **Reset:**
  - Every output register goes to 0: `enable_ex`, `control_in`, `src1`, `src2`, `imm`, `mem_req`, `retire`, `illegal_op`, `err`.
  - FIFO is emptied, so `in_ready`=1 after reset.
  - FSM goes to `IDLE`.
  - Reset in the middle of `MEM_WAIT` drops the in-flight instruction with no retire.

## Timing
- **Issue latency:** an instruction pushed at edge E into an empty FIFO with the FSM in `IDLE` has `enable_ex`=1 during the cycle E+1 to E+2 (one cycle).
- **ALU/shift throughput:** one instruction per cycle.
- **Memory op occupancy:** (cycles until `mem_ack` sampled high) + 1. An ack already high on the first `MEM_WAIT` cycle gives a one-cycle memory op.
- **`in_ready`:** derived from the registered count. It deasserts the cycle after the count reaches `DEPTH`.

## Configuration
- **Macro:** `DLX_SEQ_TIMEOUT_EN`.
- **Defined:**
  - A counter runs in `MEM_WAIT`. It resets on entry and on `mem_ack`.
  - When it reaches `MEM_TIMEOUT` with no ack: go to `ERR`, set `err`=1, and drop `mem_req` and `enable_ex`. The instruction is discarded without `retire`.
  - `ERR` pops nothing.
  - `clr_err`=1 clears `err` and returns to `IDLE` on the next edge.
  - A `mem_ack` on the same edge as the timeout wins: the instruction retires and there is no error.
- **Undefined:**
  - No counter and no `ERR` state; `MEM_WAIT` waits indefinitely.
  - `err`=0 constantly and `clr_err` is ignored.

## Test plan
- **Reset:** assert `rst`=0 mid-run → all outputs 0, `in_ready`=1, a later push issues normally.
- **Back-to-back ADD:** push 4 ADDs (opselect 001, op 000, src1=5, src2=7) on consecutive cycles → `enable_ex` high for 4 consecutive cycles, `control_in`=7'b0001000, 4 `retire` pulses.
- **Load:** push LOADWORD (opselect 101, op 011, imm=16'hFFFC); ack 3 cycles after `mem_req` rises → `imm`=32'hFFFFFFFC, `enable_ex` and `mem_req` high for 4 cycles, one `retire` on the ack cycle.
- **Full FIFO:** hold a store in `MEM_WAIT` and push until `in_ready`=0 → exactly `DEPTH` accepted. Ack → all entries drain in order.
- **Illegal opselect:** push opselect 011 → `illegal_op` pulse, no `enable_ex`, FIFO empty next cycle.
- **Timeout (with `DLX_SEQ_TIMEOUT_EN`):** no ack for 15 cycles → `err`=1, `mem_req`=0. Pulse `clr_err` → `err`=0 and the next queued instruction issues.
